aes_inv_round_ctrl: RTL

//  Iterative AES decryption round sequencer. Accepts a ciphertext block, applies the initial AddRoundKey,

---
 rtl/aes_inv_round_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES decryption round sequencer: initial AddRoundKey on accept, then one
// external inverse round per cycle, holding the plaintext until the consumer takes it.
module aes_inv_round_ctrl #(
  parameter int NR  = 10,
  parameter int KIW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data,
  input  logic           flush,
  output logic           busy,
  output logic [KIW-1:0] rk_idx,
  input  logic [127:0]   rk_i,
  output logic [127:0]   dp_state,
  output logic           dp_last,
  input  logic [127:0]   dp_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [KIW-1:0] NR_K  = KIW'(NR);
  localparam logic [KIW-1:0] ONE_K = KIW'(1);

  fsm_t           fsm, fsm_n;
  logic [127:0]   state_q, state_n;
  logic [KIW-1:0] cnt, cnt_n;
  logic           out_valid_n;
  logic [127:0]   out_data_n;

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      state_q   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      fsm       <= fsm_n;
      state_q   <= state_n;
      cnt       <= cnt_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

  always_comb begin
    // NOTE: every target gets a hold-value default first, so no path can infer a latch.
    fsm_n       = fsm;
    state_n     = state_q;
    cnt_n       = cnt;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    if (flush) begin
      // Abort keeps the datapath state and last plaintext; only control is cleared.
      fsm_n       = IDLE;
      cnt_n       = '0;
      out_valid_n = 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_n = in_data ^ rk_i;
            cnt_n   = NR_K;
            fsm_n   = ROUND;
          end
        end
        ROUND: begin
          state_n = dp_result;
          cnt_n   = cnt - ONE_K;
          if (cnt == ONE_K) begin
            fsm_n       = DONE;
            out_data_n  = dp_result;
            out_valid_n = 1'b1;
          end
        end
        DONE: begin
          // No accept here even with in_valid: the return to IDLE costs one bubble.
          if (out_ready) begin
            fsm_n       = IDLE;
            out_valid_n = 1'b0;
          end
        end
        default: begin
          fsm_n = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    in_ready = (fsm == IDLE);
    busy     = (fsm != IDLE);
    dp_last  = (fsm == ROUND) && (cnt == ONE_K);
    if (fsm == ROUND) rk_idx = cnt - ONE_K;
    else              rk_idx = NR_K;
  end

  assign dp_state = state_q;

endmodule
